// File: rtl/pipe_scroller.sv
// Purpose: moves a ring of NUM_PIPES obstacles left by `speed` per qualifying step, respawns them, scores passes, ramps speed.
// Latency: 1 cycle from a sampled step & run to updated positions, score_inc, score and speed (all registered).
// Backpressure: none; a step is consumed in the cycle it is seen, and step with run low is ignored.
module pipe_scroller #(
  parameter int          NUM_PIPES  = 4,
  parameter int          PIPE_SEP   = 250,
  parameter int          PIPE_W     = 52,
  parameter int          SCREEN_W   = 640,
  parameter int          Y_MIN      = 60,
  parameter int          Y_BITS     = 8,
  parameter logic [15:0] LFSR_SEED  = 16'hACE1,
  parameter int          SPEED_MAX  = 4,
  parameter int          RAMP_EVERY = 10
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     step,
  input  logic                     run,
  input  logic                     clear,
  input  logic [9:0]               bird_x,
  output logic [11*NUM_PIPES-1:0]  pipe_x_flat,
  output logic [10*NUM_PIPES-1:0]  pipe_y_flat,
  output logic                     score_inc,
  output logic [15:0]              score,
  output logic [2:0]               speed
);

  localparam int RW = (RAMP_EVERY > 1) ? $clog2(RAMP_EVERY) : 1;

  // Positions are held with guard bits: spawn X can exceed 1023, and an
  // off-screen-right pipe must never look like an off-screen-left one.
  localparam logic signed [15:0] PW_S        = 16'(PIPE_W);
  localparam logic signed [15:0] SEP_S       = 16'(PIPE_SEP);
  localparam logic [9:0]         Y_RST       = 10'(Y_MIN + (1 << (Y_BITS - 1)));
  localparam logic [9:0]         Y_MIN_V     = 10'(Y_MIN);
  localparam logic [2:0]         SPEED_MAX_V = 3'(SPEED_MAX);

  logic signed [15:0] x_q [NUM_PIPES];
  logic signed [15:0] x_d [NUM_PIPES];
  logic signed [15:0] nx  [NUM_PIPES];
  logic [9:0]         y_q [NUM_PIPES];
  logic [9:0]         y_d [NUM_PIPES];
  logic [15:0]        lfsr_q, lfsr_d;
  logic [15:0]        score_q, score_d;
  logic [2:0]         speed_q, speed_d;
  logic [RW-1:0]      ramp_q, ramp_d;
  logic               inc_q, inc_d;
  logic               pass;
  logic signed [15:0] bird_s;

  function automatic logic signed [15:0] spawn_x(input int i);
    return 16'(SCREEN_W + i * PIPE_SEP);
  endfunction

  // Galois LFSR, free-running so the player's timing seeds the gap heights.
  always_comb begin
    lfsr_d = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? 16'hB400 : 16'h0000);
  end

  // Per-pipe move, respawn behind the predecessor's new position, and pass detection.
  always_comb begin
    bird_s = signed'({6'd0, bird_x});
    pass   = 1'b0;
    for (int i = 0; i < NUM_PIPES; i++) begin
      nx[i] = x_q[i] - signed'({13'd0, speed_q});
    end
    for (int i = 0; i < NUM_PIPES; i++) begin
      x_d[i] = nx[i];
      y_d[i] = y_q[i];
      if (nx[i] + PW_S <= 16'sd0) begin
        x_d[i] = nx[(i + NUM_PIPES - 1) % NUM_PIPES] + SEP_S;
        y_d[i] = Y_MIN_V + 10'(lfsr_q[Y_BITS-1:0]);
      end
      if ((x_q[i] + PW_S >= bird_s) && (nx[i] + PW_S < bird_s)) begin
        pass = 1'b1;
      end
    end
  end

  // Saturating score, ramp counter and speed increment on a pass.
  always_comb begin
    score_d = score_q;
    speed_d = speed_q;
    ramp_d  = ramp_q;
    inc_d   = 1'b0;
    if (pass) begin
      inc_d = 1'b1;
      if (score_q != 16'hFFFF) begin
        score_d = score_q + 16'd1;
      end
      if (int'(ramp_q) == RAMP_EVERY - 1) begin
        ramp_d = '0;
        if (speed_q < SPEED_MAX_V) begin
          speed_d = speed_q + 3'd1;
        end
      end else begin
        ramp_d = ramp_q + 1'b1;
      end
    end
  end

  // LFSR is only reset by rst; clear leaves it running.
  always_ff @(posedge clk) begin
    if (rst) begin
      lfsr_q <= LFSR_SEED;
    end else begin
      lfsr_q <= lfsr_d;
    end
  end

  // Game state: rst/clear reinitialise, otherwise commit a move on step & run only.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      for (int i = 0; i < NUM_PIPES; i++) begin
        x_q[i] <= spawn_x(i);
        y_q[i] <= Y_RST;
      end
      score_q <= 16'd0;
      speed_q <= 3'd1;
      ramp_q  <= '0;
      inc_q   <= 1'b0;
    end else if (step && run) begin
      for (int i = 0; i < NUM_PIPES; i++) begin
        x_q[i] <= x_d[i];
        y_q[i] <= y_d[i];
      end
      score_q <= score_d;
      speed_q <= speed_d;
      ramp_q  <= ramp_d;
      inc_q   <= inc_d;
    end else begin
      inc_q <= 1'b0;
    end
  end

  // Flatten registered state onto the output buses.
  always_comb begin
    pipe_x_flat = '0;
    pipe_y_flat = '0;
    for (int i = 0; i < NUM_PIPES; i++) begin
      pipe_x_flat[11*i +: 11] = x_q[i][10:0];
      pipe_y_flat[10*i +: 10] = y_q[i];
    end
    score_inc = inc_q;
    score     = score_q;
    speed     = speed_q;
  end

endmodule

// File: tb/tb_pipe_scroller.sv
// Purpose: directed bench for pipe_scroller with default parameters.
// Latency: expects all outputs one edge after a sampled step.
// Backpressure: none; inputs driven on negedge, outputs sampled on negedge.
module tb_pipe_scroller;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        step = 1'b0;
  logic        run = 1'b0;
  logic        clear = 1'b0;
  logic [9:0]  bird_x = 10'd0;
  logic [43:0] pipe_x_flat;
  logic [39:0] pipe_y_flat;
  logic        score_inc;
  logic [15:0] score;
  logic [2:0]  speed;

  int checks = 0;
  int errors = 0;
  int seen   = 0;
  int exp_y  = 0;

  // Reference LFSR: Galois, mask B400, shifting every cycle out of reset.
  logic [15:0] ml;

  pipe_scroller dut (
    .clk         (clk),
    .rst         (rst),
    .step        (step),
    .run         (run),
    .clear       (clear),
    .bird_x      (bird_x),
    .pipe_x_flat (pipe_x_flat),
    .pipe_y_flat (pipe_y_flat),
    .score_inc   (score_inc),
    .score       (score),
    .speed       (speed)
  );

  always #5 clk = ~clk;

  // Independent model of the height generator.
  always @(posedge clk) begin
    if (rst) ml <= 16'hACE1;
    else     ml <= {1'b0, ml[15:1]} ^ (ml[0] ? 16'hB400 : 16'h0000);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic chk_x(input int i, input int e);
    logic [10:0] e11;
    logic [10:0] o11;
    e11 = 11'(e);
    o11 = pipe_x_flat[11*i +: 11];
    chk($sformatf("pipe_x%0d", i), {21'd0, o11}, {21'd0, e11});
  endtask

  task automatic chk_y(input int i, input int e);
    logic [9:0] o10;
    o10 = pipe_y_flat[10*i +: 10];
    chk($sformatf("pipe_y%0d", i), {22'd0, o10}, 32'(e));
  endtask

  task automatic chk_reset_state(input string tag);
    chk_x(0, 640); chk_x(1, 890); chk_x(2, 1140); chk_x(3, 1390);
    for (int i = 0; i < 4; i++) chk_y(i, 188);
    chk({tag, "_speed"}, {29'd0, speed}, 32'd1);
    chk({tag, "_score"}, {16'd0, score}, 32'd0);
    chk({tag, "_inc"}, {31'd0, score_inc}, 32'd0);
  endtask

  // n back-to-back qualifying (if run) steps; outputs settled on return.
  task automatic run_steps(input int n);
    @(negedge clk);
    step = 1'b1;
    repeat (n) @(negedge clk);
    step = 1'b0;
  endtask

  // Step continuously until the total pass count reaches target, bounded.
  task automatic pass_until(input int target);
    int budget;
    budget = 20000;
    @(negedge clk);
    step = 1'b1;
    while (seen < target && budget > 0) begin
      @(negedge clk);
      budget--;
      if (score_inc) seen++;
    end
    step = 1'b0;
    chk($sformatf("passes_reached_%0d", target), 32'(seen), 32'(target));
    chk($sformatf("score_at_%0d", target), {16'd0, score}, 32'(target));
  endtask

  initial begin
    // Reset
    repeat (3) @(negedge clk);
    rst = 1'b0;
    chk_reset_state("reset");

    // 100 steps with run high, bird at 0 so nothing scores
    run = 1'b1;
    run_steps(100);
    chk_x(0, 540); chk_x(1, 790); chk_x(2, 1040); chk_x(3, 1290);
    chk("run_score", {16'd0, score}, 32'd0);

    // 100 strobes with run low: frozen
    run = 1'b0;
    run_steps(100);
    chk_x(0, 540); chk_x(1, 790); chk_x(2, 1040); chk_x(3, 1290);
    chk("frozen_inc", {31'd0, score_inc}, 32'd0);

    // Bring pipe 0 to x=99 (right edge 151), then pass bird at 150
    run = 1'b1;
    run_steps(441);
    chk_x(0, 99);
    bird_x = 10'd150;
    run_steps(1);
    chk_x(0, 98);
    chk("edge150_inc", {31'd0, score_inc}, 32'd0);
    chk("edge150_score", {16'd0, score}, 32'd0);
    run_steps(1);
    chk_x(0, 97);
    chk("pass_inc", {31'd0, score_inc}, 32'd1);
    chk("pass_score", {16'd0, score}, 32'd1);
    @(negedge clk);
    chk("pass_inc_drop", {31'd0, score_inc}, 32'd0);
    seen = 1;

    // Speed ramp
    pass_until(9);
    chk("speed_at_9", {29'd0, speed}, 32'd1);
    pass_until(10);
    chk("speed_at_10", {29'd0, speed}, 32'd2);
    pass_until(20);
    chk("speed_at_20", {29'd0, speed}, 32'd3);
    pass_until(40);
    chk("speed_at_40", {29'd0, speed}, 32'd4);
    pass_until(50);
    chk("speed_at_50", {29'd0, speed}, 32'd4);

    // Clear alone: back to spawn layout; LFSR keeps running
    @(negedge clk);
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    chk_reset_state("clear");

    // Walk pipe 0 to x=-51, then respawn
    bird_x = 10'd0;
    run_steps(691);
    chk_x(0, -51);
    chk_x(3, 699);
    @(negedge clk);
    step = 1'b1;
    exp_y = 60 + int'(ml[7:0]);
    @(negedge clk);
    step = 1'b0;
    chk_x(0, 948);
    chk_y(0, exp_y);
    chk_x(1, 198); chk_x(2, 448); chk_x(3, 698);
    chk_y(3, 188);
    chk("respawn_inc", {31'd0, score_inc}, 32'd0);

    // Clear coincident with a step that would otherwise score (pipe 1 right edge 250 -> 249)
    bird_x = 10'd250;
    @(negedge clk);
    clear = 1'b1;
    step  = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    step  = 1'b0;
    chk_reset_state("clear_step");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
